dmem_port: RTL and testbench

DMEM_PORT -- requirements
Module: dmem_port

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_rsp_fifo.sv | 65 ++++++
 rtl/dmem_port.sv | 105 ++++++++++
 tb/tb_dmem_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: access-size encodings and the
// byte-lane helpers used by the store-merge and load-extract paths.
// Helpers handle words up to 8 bytes wide (WORD_LOG2 <= 3).
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned MAX_LANES = 8;

  // Byte-enable mask for an access of 2^size bytes starting at lane off.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [2:0] off);
    logic [8:0] span;
    span = 9'((9'd1 << (4'd1 << size)) - 9'd1);
    return 8'(span << off);
  endfunction

  // Zero- or sign-extend the low 2^size bytes of raw to the full width.
  function automatic logic [63:0] extend(input logic [63:0] raw,
                                         input logic [1:0]  size,
                                         input logic        sgn);
    logic [63:0] r;
    r = raw;
    case (size)
      SZ_BYTE: r = {{56{sgn & raw[7]}},  raw[7:0]};
      SZ_HALF: r = {{48{sgn & raw[15]}}, raw[15:0]};
      SZ_WORD: r = {{32{sgn & raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Two-entry in-order response queue for dmem_port.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (empties queue)
//   push, push_rdata,
//   push_err          - enqueue a response (caller guarantees occ < 2)
//   pop               - dequeue the head (caller guarantees head_valid)
//   head_valid/rdata/
//   head_err          - registered head of queue
//   occ               - number of queued responses (0..2)
module dmem_rsp_fifo #(
  parameter int unsigned DBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DBITS-1:0] push_rdata,
  input  logic             push_err,
  input  logic             pop,
  output logic             head_valid,
  output logic [DBITS-1:0] head_rdata,
  output logic             head_err,
  output logic [1:0]       occ
);

  logic [DBITS-1:0] e1_rdata;
  logic             e1_err;

  assign head_valid = (occ != 2'd0);

  // Entry 0 is always the head, so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ        <= 2'd0;
      head_rdata <= '0;
      head_err   <= 1'b0;
      e1_rdata   <= '0;
      e1_err     <= 1'b0;
    end else if (push && !pop) begin
      if (occ == 2'd0) begin
        head_rdata <= push_rdata;
        head_err   <= push_err;
      end else begin
        e1_rdata <= push_rdata;
        e1_err   <= push_err;
      end
      occ <= occ + 2'd1;
    end else if (pop && !push) begin
      head_rdata <= e1_rdata;
      head_err   <= e1_err;
      occ        <= occ - 2'd1;
    end else if (push && pop) begin
      // Occupancy unchanged; the new entry lands behind whatever remains.
      if (occ == 2'd1) begin
        head_rdata <= push_rdata;
        head_err   <= push_err;
      end else begin
        head_rdata <= e1_rdata;
        head_err   <= e1_err;
        e1_rdata   <= push_rdata;
        e1_err     <= push_err;
      end
    end
  end

endmodule

// File: rtl/dmem_port.sv
// Single-port data memory with valid/ready request and response channels.
// Loads and stores of byte/half/word size; faults on oversize, misaligned or
// out-of-range accesses. The load result is formed in the acceptance cycle
// and queued, giving one-cycle response latency and store-to-load coherence.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req_valid/req_ready        - request handshake
//   req_we, req_size,
//   req_signed, req_addr,
//   req_wdata                  - request payload (wdata right-aligned)
//   rsp_valid/rsp_ready        - response handshake
//   rsp_rdata, rsp_err         - extended load data (0 on store/error), fault
module dmem_port
  import dmem_pkg::*;
#(
  parameter  int unsigned ADDR_BITS = 13,
  parameter  int unsigned WORD_LOG2 = 2,
  parameter  int unsigned WORDS     = 2048,
  localparam int unsigned DBITS     = 8 << WORD_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DBITS-1:0]     req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DBITS-1:0]     rsp_rdata,
  output logic                 rsp_err
);

  localparam int unsigned NLANES   = 1 << WORD_LOG2;
  localparam int unsigned IDX_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [DBITS-1:0]     mem [WORDS];

  logic [WORD_LOG2-1:0] off;
  logic [ADDR_BITS-1:0] word;
  logic [IDX_BITS-1:0]  idx;
  logic                 size_bad;
  logic                 misalign;
  logic                 range_bad;
  logic                 err_c;
  logic [NLANES-1:0]    mask;
  logic [DBITS-1:0]     wdata_sh;
  logic [DBITS-1:0]     rd_word;
  logic [63:0]          ext_c;
  logic [DBITS-1:0]     rdata_c;
  logic                 accept;
  logic                 pop;
  logic [1:0]           occ;

  // Address decode and fault detection.
  assign off       = req_addr[WORD_LOG2-1:0];
  assign word      = req_addr >> WORD_LOG2;
  assign idx       = IDX_BITS'(word);
  assign size_bad  = 32'(req_size) > 32'(WORD_LOG2);
  assign misalign  = |(req_addr[2:0] & 3'((4'd1 << req_size) - 4'd1));
  assign range_bad = 64'(word) >= 64'(WORDS);
  assign err_c     = size_bad | misalign | range_bad;

  // Store lanes: shift data and enables up to the addressed byte.
  assign mask     = NLANES'(lane_mask(req_size, 3'(off)));
  assign wdata_sh = req_wdata << {off, 3'b000};

  // Load path reads the array in the acceptance cycle; a store accepted on the
  // previous edge is therefore already visible.
  assign rd_word = mem[idx];
  assign ext_c   = extend(64'(rd_word >> {off, 3'b000}), req_size, req_signed);
  assign rdata_c = (req_we || err_c) ? '0 : DBITS'(ext_c);

  // Handshakes; readiness depends only on reset and queue occupancy.
  assign req_ready = !reset && (occ != 2'd2);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Memory array has no reset; accept is already masked by reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err_c) begin
      for (int i = 0; i < NLANES; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  dmem_rsp_fifo #(
    .DBITS(DBITS)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_rdata (rdata_c),
    .push_err   (err_c),
    .pop        (pop),
    .head_valid (rsp_valid),
    .head_rdata (rsp_rdata),
    .head_err   (rsp_err),
    .occ        (occ)
  );

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port with a byte-array reference model and a
// response scoreboard queue.
module tb_dmem_port;

  localparam int unsigned AB = 14;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AB-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  dmem_port #(
    .ADDR_BITS (AB),
    .WORD_LOG2 (2),
    .WORDS     (2048)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mb [8192];
  exp_t        q [$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          n_rsp = 0;
  logic        last_acc = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic        prev_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed memory, little-endian assembly.
  task automatic predict(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [AB-1:0] a, input logic [31:0] wd, output exp_t e);
    int          n;
    logic [63:0] v;
    n       = 1 << sz;
    e.err   = (sz > 2'd2) || ((int'(a) % n) != 0) || ((int'(a) >> 2) >= 2048);
    e.rdata = '0;
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < n; b++) mb[int'(a) + b] = wd[8*b +: 8];
      end else begin
        v = '0;
        for (int b = 0; b < n; b++) v[8*b +: 8] = mb[int'(a) + b];
        if (sg && v[8*n-1]) begin
          for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
        end
        e.rdata = v[31:0];
      end
    end
  endtask

  // One clock: sample at negedge+1, score handshakes, advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    last_acc = 1'b0;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("rsp_valid_vs_pending", 32'(rsp_valid), 32'(q.size() != 0));
      chk("req_ready_vs_occ", 32'(req_ready), 32'(q.size() < 2));
      if (prev_stall) begin
        chk("hold_rdata", rsp_rdata, prev_rdata);
        chk("hold_err", 32'(rsp_err), 32'(prev_err));
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_without_request", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          n_rsp++;
        end
      end
      if (req_valid && req_ready) begin
        predict(req_we, req_size, req_signed, req_addr, req_wdata, e);
        q.push_back(e);
        n_acc++;
        last_acc = 1'b1;
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err   = rsp_err;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [AB-1:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [AB-1:0] a, input logic [31:0] wd);
    drive(we, sz, sg, a, wd);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 32'(last_acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0;
    int          r0;
    int          ready_low;
    logic [1:0]  sz;
    logic [AB-1:0] a;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Word store/load round trip.
    send(1'b1, 2'd2, 1'b0, 14'h10, 32'hDEADBEEF);
    send(1'b0, 2'd2, 1'b0, 14'h10, 32'h0);
    idle(1);

    // Byte store and signed/unsigned byte loads.
    send(1'b1, 2'd0, 1'b0, 14'h13, 32'h00000080);
    send(1'b0, 2'd0, 1'b1, 14'h13, 32'h0);
    send(1'b0, 2'd0, 1'b0, 14'h13, 32'h0);
    send(1'b0, 2'd2, 1'b0, 14'h10, 32'h0);
    send(1'b0, 2'd1, 1'b1, 14'h12, 32'h0);
    idle(1);

    // Faults: misaligned, oversize, out of range; erroring store writes nothing.
    send(1'b0, 2'd1, 1'b0, 14'h11, 32'h0);
    send(1'b1, 2'd2, 1'b0, 14'h12, 32'h12345678);
    send(1'b0, 2'd2, 1'b0, 14'h10, 32'h0);
    send(1'b0, 2'd2, 1'b0, 14'h2000, 32'h0);
    send(1'b0, 2'd3, 1'b0, 14'h10, 32'h0);
    idle(1);

    // Back-pressure: two accepted, third held until the queue drains.
    rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 14'h10, 32'h0);
    tick();
    drive(1'b0, 2'd0, 1'b0, 14'h10, 32'h0);
    tick();
    drive(1'b0, 2'd1, 1'b1, 14'h12, 32'h0);
    tick();
    tick();
    chk("ready_low_when_full", 32'(req_ready), 32'd0);
    chk("held_pending", 32'(q.size()), 32'd2);
    rsp_ready = 1'b1;
    send(1'b0, 2'd1, 1'b1, 14'h12, 32'h0);
    idle(3);
    chk("drained", 32'(q.size()), 32'd0);

    // Streaming: one request per cycle for 100 cycles.
    a0 = n_acc;
    r0 = n_rsp;
    ready_low = 0;
    for (int i = 0; i < 100; i++) begin
      if ((i % 2) == 0) begin
        drive(1'b1, 2'd2, 1'b0, 14'(32'h200 + 4 * (i / 2)), $urandom());
      end else begin
        sz = 2'((i / 2) % 3);
        a  = 14'(32'h200 + 4 * (i / 2));
        if (sz == 2'd0) a = a + 14'((i / 2) % 4);
        if (sz == 2'd1) a = a + 14'(2 * ((i / 2) % 2));
        drive(1'b0, sz, 1'(i >> 1), a, 32'h0);
      end
      tick();
      if (!last_acc) ready_low++;
    end
    idle(2);
    chk("stream_ready_never_low", 32'(ready_low), 32'd0);
    chk("stream_accepts", 32'(n_acc - a0), 32'd100);
    chk("stream_responses", 32'(n_rsp - r0), 32'd100);

    // Reset with a full queue and a store presented during reset.
    rsp_ready = 1'b0;
    send(1'b0, 2'd2, 1'b0, 14'h10, 32'h0);
    send(1'b0, 2'd2, 1'b0, 14'h10, 32'h0);
    chk("full_before_reset", 32'(q.size()), 32'd2);
    drive(1'b1, 2'd2, 1'b0, 14'h10, 32'h11111111);
    reset = 1'b1;
    tick();
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_reset_req_ready", 32'(req_ready), 32'd0);
    chk("mid_reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("mid_reset_rsp_err", 32'(rsp_err), 32'd0);
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("ready_after_reset2", 32'(req_ready), 32'd1);
    @(negedge clk);
    idle(2);
    send(1'b0, 2'd2, 1'b0, 14'h10, 32'h0);
    send(1'b0, 2'd2, 1'b0, 14'h204, 32'h0);
    idle(2);
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
